// File: rtl/design_mux_sequencer.sv
// Pad-bus multiplexer over NUM_DES design slots with a blank / reset / run slot switch.
// Optional MUX_OUT_REG_EN registers io_out, which adds one cycle of output latency.
module design_mux_sequencer #(
    parameter int NUM_DES           = 64,
    parameter int IO_W              = 12,
    parameter int SEL_W             = 6,
    parameter int SYNC_STAGES       = 2,
    parameter int SWITCH_RST_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [IO_W-1:0]         io_in,
    output logic [IO_W-1:0]         io_out,
    input  logic [SEL_W-1:0]        des_sel,
    input  logic                    hold_if_not_sel,
    input  logic                    sync_inputs,
    output logic [NUM_DES*IO_W-1:0] des_io_in,
    input  logic [NUM_DES*IO_W-1:0] des_io_out,
    output logic [NUM_DES-1:0]      des_reset,
    output logic [SEL_W-1:0]        active_sel,
    output logic                    switching
);
    localparam int CNT_W = $clog2(SWITCH_RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWITCH_RST_CYCLES - 1);

    typedef enum logic [1:0] {SLOT_RST, RUN, BLANK} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  active_q, active_d;

    logic [SEL_W-1:0]  sel_meta_q, sel_s_q;
    logic              hold_meta_q, hold_s_q;
    logic [IO_W-1:0]   in_pipe_q [SYNC_STAGES];
    logic [IO_W-1:0]   in_s;
    logic [IO_W-1:0]   mux_out;
    logic [IO_W-1:0]   run_val;

    // Synchronisers: select and hold always, pad inputs when sync_inputs is set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_meta_q  <= '0;
            sel_s_q     <= '0;
            hold_meta_q <= 1'b0;
            hold_s_q    <= 1'b0;
            for (int k = 0; k < SYNC_STAGES; k++) in_pipe_q[k] <= '0;
        end else begin
            sel_meta_q   <= des_sel;
            sel_s_q      <= sel_meta_q;
            hold_meta_q  <= hold_if_not_sel;
            hold_s_q     <= hold_meta_q;
            in_pipe_q[0] <= io_in;
            for (int k = 1; k < SYNC_STAGES; k++) in_pipe_q[k] <= in_pipe_q[k-1];
        end
    end

    assign in_s = sync_inputs ? in_pipe_q[SYNC_STAGES-1] : io_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= SLOT_RST;
            cnt_q    <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        case (state_q)
            SLOT_RST: begin
                // A new request during the reset window restarts the window on the new slot
                if (sel_s_q != active_q) begin
                    active_d = sel_s_q;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (sel_s_q != active_q) state_d = BLANK;
            end
            BLANK: begin
                active_d = sel_s_q;
                cnt_d    = '0;
                state_d  = SLOT_RST;
            end
            default: begin
                state_d = SLOT_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Slot gating; an unpopulated active_sel matches no slot and so drives nothing
    always_comb begin
        des_io_in = '0;
        des_reset = {NUM_DES{hold_s_q}};
        mux_out   = '0;
        if (!reset) begin
            des_reset = '1;
        end else begin
            for (int i = 0; i < NUM_DES; i++) begin
                if (active_q == SEL_W'(i)) begin
                    des_io_in[i*IO_W +: IO_W] = (state_q == BLANK) ? '0 : in_s;
                    des_reset[i]              = (state_q != RUN);
                    mux_out                   = des_io_out[i*IO_W +: IO_W];
                end
            end
        end
    end

    assign run_val    = (state_q == RUN) ? mux_out : '0;
    assign active_sel = active_q;

`ifdef MUX_OUT_REG_EN
    logic [IO_W-1:0] out_q;
    logic            run_seen_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            run_seen_q <= 1'b0;
        end else begin
            out_q      <= run_val;
            run_seen_q <= (state_q == RUN);
        end
    end

    assign io_out    = out_q;
    assign switching = !((state_q == RUN) && run_seen_q);
`else
    assign io_out    = run_val;
    assign switching = (state_q != RUN);
`endif

endmodule

// File: tb/tb_design_mux_sequencer.sv
// Directed bench for design_mux_sequencer: reset, slot switching, restart, hold, input sync, unpopulated slot.
module tb_design_mux_sequencer;
    localparam int NUM_DES = 44;
    localparam int IO_W    = 12;
    localparam int SEL_W   = 6;
    localparam int NRC     = 4;
    localparam logic [NUM_DES-1:0] ALL1 = '1;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [IO_W-1:0]         io_in;
    logic [IO_W-1:0]         io_out;
    logic [SEL_W-1:0]        des_sel;
    logic                    hold_if_not_sel;
    logic                    sync_inputs;
    logic [NUM_DES*IO_W-1:0] des_io_in;
    logic [NUM_DES*IO_W-1:0] des_io_out;
    logic [NUM_DES-1:0]      des_reset;
    logic [SEL_W-1:0]        active_sel;
    logic                    switching;

    always #5 clock = ~clock;

    design_mux_sequencer #(
        .NUM_DES(NUM_DES), .IO_W(IO_W), .SEL_W(SEL_W),
        .SYNC_STAGES(2), .SWITCH_RST_CYCLES(NRC)
    ) dut (
        .clock(clock), .reset(reset), .io_in(io_in), .io_out(io_out),
        .des_sel(des_sel), .hold_if_not_sel(hold_if_not_sel), .sync_inputs(sync_inputs),
        .des_io_in(des_io_in), .des_io_out(des_io_out), .des_reset(des_reset),
        .active_sel(active_sel), .switching(switching)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [SEL_W-1:0]   sel;
        logic               hold;
        logic [IO_W-1:0]    pad;
        logic [IO_W-1:0]    exp_out;
        logic               exp_sw;
        logic [SEL_W-1:0]   exp_act;
        logic [NUM_DES-1:0] exp_rst;
        logic [IO_W-1:0]    exp_din;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [IO_W-1:0] slot_val(int i);
        return (i == 0) ? 12'hA5A : IO_W'(12'h300 + i);
    endfunction

    function automatic logic [NUM_DES-1:0] bit_(int k);
        return NUM_DES'(1) << k;
    endfunction

    function automatic logic [NUM_DES*IO_W-1:0] din_vec(int act, logic [IO_W-1:0] val);
        logic [NUM_DES*IO_W-1:0] v;
        v = '0;
        if (act < NUM_DES) v[act*IO_W +: IO_W] = val;
        return v;
    endfunction

    task automatic chk(input string name, input logic [NUM_DES*IO_W-1:0] act,
                       input logic [NUM_DES*IO_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic addn(input int n, input logic [SEL_W-1:0] sel, input logic hold,
                        input logic [IO_W-1:0] pad, input logic [IO_W-1:0] eo,
                        input logic esw, input logic [SEL_W-1:0] eact,
                        input logic [NUM_DES-1:0] erst, input logic [IO_W-1:0] edin);
        vec_t v;
        v.sel = sel; v.hold = hold; v.pad = pad; v.exp_out = eo;
        v.exp_sw = esw; v.exp_act = eact; v.exp_rst = erst; v.exp_din = edin;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Slot 0 -> 1 (hold off)
        addn(2, 1, 0, 12'h0C3, 12'hA5A, 0, 0, '0,       12'h0C3);
        addn(1, 1, 0, 12'h0C3, 12'h000, 1, 0, bit_(0),  12'h000);
        addn(4, 1, 0, 12'h0C3, 12'h000, 1, 1, bit_(1),  12'h0C3);
        addn(1, 1, 0, 12'h0C3, 12'h301, 0, 1, '0,       12'h0C3);
        // Slot 1 -> 5
        addn(2, 5, 0, 12'h0C3, 12'h301, 0, 1, '0,       12'h0C3);
        addn(1, 5, 0, 12'h0C3, 12'h000, 1, 1, bit_(1),  12'h000);
        addn(4, 5, 0, 12'h0C3, 12'h000, 1, 5, bit_(5),  12'h0C3);
        addn(1, 5, 0, 12'h0C3, 12'h305, 0, 5, '0,       12'h0C3);
        // Slot 5 -> 0 with hold on
        addn(1, 0, 1, 12'h0C3, 12'h305, 0, 5, '0,               12'h0C3);
        addn(1, 0, 1, 12'h0C3, 12'h305, 0, 5, ALL1 & ~bit_(5),  12'h0C3);
        addn(1, 0, 1, 12'h0C3, 12'h000, 1, 5, ALL1,             12'h000);
        addn(4, 0, 1, 12'h0C3, 12'h000, 1, 0, ALL1,             12'h0C3);
        addn(1, 0, 1, 12'h0C3, 12'hA5A, 0, 0, ALL1 & ~bit_(0),  12'h0C3);
        // Slot 0 -> 5, redirected to 7 while slot 5 is in its reset window
        addn(2, 5, 1, 12'h0C3, 12'hA5A, 0, 0, ALL1 & ~bit_(0),  12'h0C3);
        addn(1, 5, 1, 12'h0C3, 12'h000, 1, 0, ALL1,             12'h000);
        addn(2, 7, 1, 12'h0C3, 12'h000, 1, 5, ALL1,             12'h0C3);
        addn(4, 7, 1, 12'h0C3, 12'h000, 1, 7, ALL1,             12'h0C3);
        addn(1, 7, 1, 12'h0C3, 12'h307, 0, 7, ALL1 & ~bit_(7),  12'h0C3);
        // Slot 7 -> 3 with hold on, then hold released
        addn(2, 3, 1, 12'h0C3, 12'h307, 0, 7, ALL1 & ~bit_(7),  12'h0C3);
        addn(1, 3, 1, 12'h0C3, 12'h000, 1, 7, ALL1,             12'h000);
        addn(4, 3, 1, 12'h0C3, 12'h000, 1, 3, ALL1,             12'h0C3);
        addn(1, 3, 1, 12'h0C3, 12'h303, 0, 3, ALL1 & ~bit_(3),  12'h0C3);
        addn(1, 3, 0, 12'h0C3, 12'h303, 0, 3, ALL1 & ~bit_(3),  12'h0C3);
        addn(1, 3, 0, 12'h0C3, 12'h303, 0, 3, '0,               12'h0C3);
        addn(1, 3, 0, 12'h5A5, 12'h303, 0, 3, '0,               12'h5A5);

        reset = 1'b0; des_sel = '0; hold_if_not_sel = 1'b0; sync_inputs = 1'b0;
        io_in = 12'h123;
        for (int i = 0; i < NUM_DES; i++) des_io_out[i*IO_W +: IO_W] = slot_val(i);
        step(); step();

        chk("rst_io_out", io_out, '0);
        chk("rst_des_reset", des_reset, ALL1);
        chk("rst_des_io_in", des_io_in, '0);
        chk("rst_switching", switching, 1'b1);
        chk("rst_active", active_sel, '0);

        io_in = 12'h0C3;
        reset = 1'b1;
        #1;
        for (int k = 0; k < NRC; k++) begin
            chk($sformatf("boot%0d_rst", k), des_reset, bit_(0));
            chk($sformatf("boot%0d_sw", k), switching, 1'b1);
            chk($sformatf("boot%0d_out", k), io_out, '0);
            step();
        end
        chk("boot_run_rst", des_reset, '0);
        chk("boot_run_sw", switching, 1'b0);
        chk("boot_run_out", io_out, 12'hA5A);
        chk("boot_run_din", des_io_in, din_vec(0, 12'h0C3));

        foreach (vecs[i]) begin
            des_sel = vecs[i].sel;
            hold_if_not_sel = vecs[i].hold;
            io_in = vecs[i].pad;
            step();
            chk($sformatf("v%0d_out", i), io_out, vecs[i].exp_out);
            chk($sformatf("v%0d_sw", i), switching, vecs[i].exp_sw);
            chk($sformatf("v%0d_act", i), active_sel, vecs[i].exp_act);
            chk($sformatf("v%0d_rst", i), des_reset, vecs[i].exp_rst);
            chk($sformatf("v%0d_din", i), des_io_in, din_vec(int'(vecs[i].exp_act), vecs[i].exp_din));
        end

        // Direct pad path: same-cycle propagation
        io_in = 12'h000; #1;
        chk("direct_a", des_io_in, din_vec(3, 12'h000));
        io_in = 12'hABC; #1;
        chk("direct_b", des_io_in, din_vec(3, 12'hABC));

        // Synchronised pad path: two-cycle propagation
        io_in = 12'h000;
        step(); step();
        sync_inputs = 1'b1; #1;
        chk("sync_pre", des_io_in, din_vec(3, 12'h000));
        io_in = 12'hFFF; #1;
        chk("sync_c0", des_io_in, din_vec(3, 12'h000));
        step();
        chk("sync_c1", des_io_in, din_vec(3, 12'h000));
        step();
        chk("sync_c2", des_io_in, din_vec(3, 12'hFFF));
        sync_inputs = 1'b0;

        // Unpopulated slot 63
        des_sel = 6'd63;
        step(); step(); step();
        chk("unpop_blank_sw", switching, 1'b1);
        chk("unpop_blank_rst", des_reset, bit_(3));
        for (int k = 0; k < NRC; k++) begin
            step();
            chk($sformatf("unpop%0d_act", k), active_sel, 6'd63);
            chk($sformatf("unpop%0d_rst", k), des_reset, '0);
            chk($sformatf("unpop%0d_sw", k), switching, 1'b1);
        end
        step();
        chk("unpop_run_sw", switching, 1'b0);
        chk("unpop_run_out", io_out, '0);
        chk("unpop_run_rst", des_reset, '0);
        chk("unpop_run_din", des_io_in, '0);

        // Asynchronous reset while in BLANK
        des_sel = '0;
        step(); step(); step();
        chk("blank_sw", switching, 1'b1);
        chk("blank_act", active_sel, 6'd63);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_act", active_sel, '0);
        chk("arst_out", io_out, '0);
        chk("arst_rst", des_reset, ALL1);
        chk("arst_din", des_io_in, '0);
        chk("arst_sw", switching, 1'b1);
        step();
        reset = 1'b1;
        #1;
        for (int k = 0; k < NRC; k++) begin
            chk($sformatf("reboot%0d_rst", k), des_reset, bit_(0));
            step();
        end
        chk("reboot_out", io_out, 12'hA5A);
        chk("reboot_sw", switching, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/design_mux_sequencer.md
Name: design_mux_sequencer

Overview:
- Parametrised successor to the fixed 64-slot design multiplexer.
- Routes the shared chip pad bus to one of NUM_DES user-design slots and gates the input and output of every slot.
- Adds a sequenced, glitch-free slot switch: blank, then reset the new slot, then run.
- Synchronises the select and control inputs.
- Sits between the pad ring and the design_instantiations slot array.

Parameters:
- NUM_DES, 64, number of design slots.
- IO_W, 12, per-slot and pad IO width.
- SEL_W, 6, select width; slots with index >= NUM_DES are unpopulated.
- SYNC_STAGES, 2, flop depth of io_in synchroniser when sync_inputs=1 (>=2).
- SWITCH_RST_CYCLES, 4, cycles the newly selected slot is held in reset (>=1).

Ports:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-low system reset.
- io_in  in  IO_W  pad inputs.
- io_out  out  IO_W  pad outputs.
- des_sel  in  SEL_W  requested slot; asynchronous, always 2-flop synchronised.
- hold_if_not_sel  in  1  1: non-active slots held in reset; 2-flop synchronised.
- sync_inputs  in  1  1: io_in passes through SYNC_STAGES flops; 0: direct; quasi-static.
- des_io_in  out  NUM_DES*IO_W  per-slot inputs, slot i at bits [i*IO_W +: IO_W].
- des_io_out  in  NUM_DES*IO_W  per-slot outputs, same packing.
- des_reset  out  NUM_DES  per-slot active-high reset.
- active_sel  out  SEL_W  slot currently connected.
- switching  out  1  high whenever state != RUN.

Behaviour:
- Reset (reset=0, async):
  - state=SLOT_RST, cnt=0, active_sel=0, sync flops cleared.
  - io_out=0, des_io_in all 0, des_reset all 1 (combinationally, while reset is low), switching=1.
- sel_s, hold_s: outputs of the 2-flop synchronisers for des_sel and hold_if_not_sel.
- FSM states: SLOT_RST, RUN, BLANK.
  - SLOT_RST:
    - des_reset[active_sel]=1, io_out=0, des_io_in[active_sel]=in_s.
    - cnt increments each cycle; at cnt==SWITCH_RST_CYCLES-1 go to RUN and clear cnt.
    - If sel_s != active_sel: active_sel<=sel_s, cnt<=0 (restart, stay in SLOT_RST).
  - RUN:
    - des_reset[active_sel]=0, des_io_in[active_sel]=in_s, io_out=des_io_out slice for active_sel.
    - If sel_s != active_sel go to BLANK.
  - BLANK (exactly 1 cycle):
    - io_out=0, des_io_in[active_sel]=0, des_reset[active_sel]=1.
    - Next: active_sel<=sel_s (value sampled this cycle), cnt<=0, go to SLOT_RST.
- in_s: io_in after SYNC_STAGES flops when sync_inputs=1, else io_in.
- Non-active slot i:
  - des_io_in[i]=0.
  - des_reset[i]=hold_s OR (state==SLOT_RST AND i was the previous slot for the first cycle).
  - Simplify: non-active des_reset[i]=hold_s only.
- Unpopulated active_sel (>= NUM_DES):
  - FSM sequences normally.
  - io_out=0; no des_reset/des_io_in bit is driven for it.
- Latency from des_sel change to the new slot being live on io_out: 2 (sync) + 1 (detect) + 1 (BLANK) + SWITCH_RST_CYCLES cycles.
- io_out in RUN is combinational from des_io_out unless MUX_OUT_REG_EN is defined.
- Reset mid-switch: returns to SLOT_RST on slot 0 immediately, async.

Optional Feature:
- Macro: MUX_OUT_REG_EN.
- Defined:
  - io_out is registered; +1 cycle latency in RUN.
  - The register loads 0 in BLANK/SLOT_RST and resets to 0.
  - switching stays high until the first registered RUN value is presented (one extra cycle after entering RUN).
- Undefined:
  - io_out is combinational from the selected des_io_out slice.
  - switching = (state != RUN).

Test Plan:
- Reset release, des_sel=0, SWITCH_RST_CYCLES=4:
  - des_reset[0]=1 for 4 cycles, then 0; switching falls.
  - des_io_out[0]=12'hA5A drives io_out=12'hA5A.
- In RUN on slot 1, set des_sel=5:
  - after 2 sync cycles, 1 BLANK cycle with io_out=0 and des_reset[1]=1;
  - then des_reset[5]=1 for 4 cycles;
  - then io_out follows slot 5; active_sel=5.
- des_sel changes 5->7 during SLOT_RST:
  - cnt restarts and active_sel=7;
  - slot 7 is held in reset a full 4 cycles; slot 5 never leaves reset.
- hold_if_not_sel=1 vs 0 while on slot 3:
  - all other des_reset bits are 1 vs 0;
  - all other des_io_in are 0 in both cases.
- sync_inputs=1 with SYNC_STAGES=2, io_in 0->12'hFFF: des_io_in[active] updates 2 cycles later.
- sync_inputs=0: des_io_in[active] updates in the same cycle.
- des_sel=63 with NUM_DES=44:
  - FSM completes to RUN with io_out=0;
  - no des_reset bit is asserted by selection;
  - async reset mid-BLANK returns to slot 0, io_out=0 immediately.
